// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream link into the loader plus the instr_mem write port
// it drives.
//   s_valid/s_data  byte stream from the host (source side)
//   s_ready         loader can take a byte; transfer when s_valid && s_ready
//   mem_we          one-cycle write strobe per assembled word
//   mem_addr        word address into instr_mem
//   mem_wdata       assembled little-endian instruction word
// Modports: slave = the loader, master = the host / memory side.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 6
) ();
    logic                  s_valid;
    logic [7:0]            s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader in front of the core's instr_mem.
// It takes a framed byte stream (CNT_LO, CNT_HI, then N little-endian words),
// writes each word into instr_mem and holds the core in reset until the whole
// image is in place.
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   load_req    one-cycle pulse, restarts a load from DONE or ERR
//   bus         prog_loader_if.slave: byte stream in, instr_mem write port out
//   core_rst_n  active-low reset to the core, high only in DONE
//   done        image loaded, core running
//   err         bad frame (bad count or checksum), core held in reset
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes before the core is released.
// Every output is a flop.
module prog_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_req,
    prog_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;       // word count N from the header
    logic [ADDR_WIDTH:0]   widx_q, widx_d;     // one bit wider so N==MAX_WORDS compares cleanly
    logic [1:0]            bcnt_q, bcnt_d;     // byte position inside the current word
    logic [23:0]           word_q, word_d;     // bytes 0..2 of the word being assembled
    logic                  s_ready_q, s_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  core_rst_n_q, core_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  accept;
    logic [15:0]           n_hdr;
    logic [ADDR_WIDTH:0]   widx_inc;

    // Handshake uses the registered s_ready, so a byte presented in the cycle
    // a load_req is taken (s_ready still low) is never consumed.
    assign accept   = bus.s_valid && s_ready_q;
    assign n_hdr    = {bus.s_data, cnt_q[7:0]};
    assign widx_inc = widx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            HDR0: begin
                if (accept) begin
                    cnt_d[7:0] = bus.s_data;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    cnt_d[15:8] = bus.s_data;
                    widx_d      = '0;
                    bcnt_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                    if (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_WORDS)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.s_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {bus.s_data, word_q};
                        widx_d      = widx_inc;
                        bcnt_d      = '0;
                        if (16'(widx_inc) == cnt_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = DONE;
`endif
                        end
                    end else begin
                        word_d[{bcnt_q, 3'b000} +: 8] = bus.s_data;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept)
                    state_d = (bus.s_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (load_req) begin
                    state_d = HDR0;
                    cnt_d   = '0;
                    widx_d  = '0;
                    bcnt_d  = '0;
                    word_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = HDR0;
        endcase

        // Outputs follow the next state, except done/core_rst_n which wait a
        // full cycle in DONE so the core comes out of reset only after the last
        // mem_we has landed.
        s_ready_d    = !(state_d == DONE || state_d == ERR);
        err_d        = (state_d == ERR);
        done_d       = (state_q == DONE) && (state_d == DONE);
        core_rst_n_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= HDR0;
            cnt_q        <= '0;
            widx_q       <= '0;
            bcnt_q       <= '0;
            word_q       <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign done          = done_q;
    assign err           = err_q;
    assign core_rst_n    = core_rst_n_q;

endmodule
